meta_array: RTL and testbench
=============================

Name: meta_array

Overview:
- Parametrised N-way cache metadata array for tags, valid/dirty bits and LRU state. Generalises the single-way register array.
- Adds:
  - per-way write enables
  - a per-bit write mask
  - a registered read with write-through bypass
  - a self-timed clear sweep (flush/invalidate-all) with a busy indication
- Sits beside the data arrays in the cache datapath and is driven by the cache control FSM.

Parameters:
- S_INDEX, 3, index width; NUM_SETS = 2**S_INDEX.
- WIDTH, 1, bits per way entry.
- WAYS, 2, number of ways (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- read  in  1  read enable; samples rindex.
- rindex  in  S_INDEX  read set index.
- load  in  WAYS  per-way write enable.
- windex  in  S_INDEX  write set index.
- wmask  in  WIDTH  bit mask; 1 = bit written, shared by all enabled ways.
- datain  in  WIDTH  write data, shared by all enabled ways.
- clear  in  1  start clear sweep (pulse).
- dataout  out  WAYS*WIDTH  registered read data; way w occupies bits [w*WIDTH +: WIDTH].
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (async, rst=1), effective immediately and independent of clk:
  - all entries 0, dataout 0, busy 0, FSM to IDLE, sweep counter 0.
  - Reset mid-sweep aborts the sweep; the array is zeroed anyway.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on a clk edge with clear=1; the counter loads 0.
  - CLEAR -> IDLE on the edge where counter == NUM_SETS-1.
- busy = (state == CLEAR). It is high for exactly NUM_SETS cycles, starting the cycle after clear is sampled.
- CLEAR sweep:
  - Each edge writes 0 to every way of set[counter], then the counter increments.
  - load is ignored (writes dropped) while busy.
  - read is ignored while busy; dataout holds.
  - clear is ignored while busy; there is no restart.
- Write (IDLE only), applied per way w with load[w]=1:
  - data[windex][w] <= (data[windex][w] & ~wmask) | (datain & wmask).
  - Ways with load[w]=0 are unchanged.
  - load = 0 leaves the array unchanged.
- Read (IDLE only): 1-cycle latency. On an edge with read=1, dataout way w <= merged value, where:
  - If load[w]=1 and windex==rindex: (data[rindex][w] & ~wmask) | (datain & wmask), i.e. the post-write value (write-through bypass).
  - Otherwise: data[rindex][w].
- read=0: dataout holds its previous value indefinitely.
- Same edge, clear=1 with read/load in IDLE: the read and write still take effect on that edge; the sweep starts next cycle and later zeroes everything.
- No combinational path from any input to dataout or busy.

Decomposition:
- Package meta_array_pkg holds:
  - the enum meta_state_e {IDLE, CLEAR}
  - a function merge(old, new, mask) returning (old & ~mask) | (new & mask), shared by the write and bypass paths.
- Sub-module meta_way: one way's storage, S_INDEX and WIDTH parameters, ports:
  - write enable, windex, wmask, datain
  - rindex, read
  - clear-write enable and clear index
  - registered output with bypass
- meta_array instantiates WAYS copies of meta_way via generate and owns the FSM and sweep counter.

Test Plan (defaults S_INDEX=3, WIDTH=8, WAYS=2 unless stated):
- Reset check: assert rst mid-cycle -> dataout=16'h0000 and busy=0 immediately, without a clk edge.
- Masked write, then read:
  - load=2'b01, windex=3, datain=8'hAB, wmask=8'hFF, then load=2'b01, datain=8'h00, wmask=8'h0F.
  - Then read=1, rindex=3 -> dataout=16'h00A0 one cycle later.
- Bypass and hold:
  - Same edge: read=1, rindex=5, load=2'b10, windex=5, datain=8'h5C, wmask=8'hFF -> next cycle dataout=16'h5C00.
  - Drop read for 4 cycles -> dataout stays 16'h5C00.
- Non-matching index: load=2'b11 at windex=2 with a read at rindex=6 on the same edge -> dataout shows the old set-6 contents (0); no bypass.
- Clear sweep:
  - Fill all 8 sets with 8'hFF, then pulse clear -> busy high exactly 8 cycles.
  - A load at windex=7 issued during busy is dropped.
  - After busy falls, reads of sets 0..7 all return 16'h0000.
- Reset mid-sweep:
  - Pulse clear, assert rst on cycle 3 of busy -> busy=0 immediately, all sets read 0.
  - A new clear after reset runs the full 8 cycles.

Source files
------------

// File: rtl/meta_array_pkg.sv
// -----------------------------------------------------------------------------
// meta_array_pkg
//   Shared types and helpers for the cache metadata array.
//   - meta_state_e : sweep controller states (IDLE, CLEAR).
//   - MERGE_W      : widest entry the merge helper handles; WIDTH must not exceed it.
//   - merge()      : masked bit merge used by both the array write path and the
//                    read bypass path, so the two can never disagree.
// -----------------------------------------------------------------------------
package meta_array_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } meta_state_e;

    localparam int MERGE_W = 64;

    // Bits with mask=1 come from new_val, bits with mask=0 keep old_val.
    function automatic logic [MERGE_W-1:0] merge(
        input logic [MERGE_W-1:0] old_val,
        input logic [MERGE_W-1:0] new_val,
        input logic [MERGE_W-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/meta_array_if.sv
// -----------------------------------------------------------------------------
// meta_array_if
//   Request/response bundle between the cache control FSM (master) and the
//   metadata array (slave).
//   Master drives : read, rindex, load[WAYS], windex, wmask, datain, clear
//   Slave drives  : dataout[WAYS*WIDTH] (way w at [w*WIDTH +: WIDTH]), busy
// -----------------------------------------------------------------------------
interface meta_array_if #(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 1,
    parameter int WAYS    = 2
);

    logic                    read;
    logic [S_INDEX-1:0]      rindex;
    logic [WAYS-1:0]         load;
    logic [S_INDEX-1:0]      windex;
    logic [WIDTH-1:0]        wmask;
    logic [WIDTH-1:0]        datain;
    logic                    clear;
    logic [WAYS*WIDTH-1:0]   dataout;
    logic                    busy;

    modport master (
        output read, rindex, load, windex, wmask, datain, clear,
        input  dataout, busy
    );

    modport slave (
        input  read, rindex, load, windex, wmask, datain, clear,
        output dataout, busy
    );

endinterface

// File: rtl/meta_way.sv
// -----------------------------------------------------------------------------
// meta_way
//   Storage for one way of the metadata array: NUM_SETS entries of WIDTH bits,
//   a masked write port, a clear-write port used by the sweep, and a registered
//   read port with write-through bypass.
//   Ports:
//     clk, rst     clock, async active-high reset (zeroes storage and output)
//     we           masked write enable for this way
//     windex       write set index
//     wmask        write bit mask (1 = bit written)
//     datain       write data
//     read         read enable (dataout updates only when set)
//     rindex       read set index
//     clr_we       sweep write enable (writes zero, wins over we)
//     clr_index    set being cleared by the sweep
//     dataout      registered read data
// -----------------------------------------------------------------------------
module meta_way
    import meta_array_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [S_INDEX-1:0] windex,
    input  logic [WIDTH-1:0]   wmask,
    input  logic [WIDTH-1:0]   datain,
    input  logic               read,
    input  logic [S_INDEX-1:0] rindex,
    input  logic               clr_we,
    input  logic [S_INDEX-1:0] clr_index,
    output logic [WIDTH-1:0]   dataout
);

    localparam int NUM_SETS = 2 ** S_INDEX;

    logic [WIDTH-1:0] mem [NUM_SETS];
    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] rd_data_p1;

    // Adapts the package-wide merge to this way's entry width.
    function automatic logic [WIDTH-1:0] merge_entry(
        input logic [WIDTH-1:0] old_val,
        input logic [WIDTH-1:0] new_val,
        input logic [WIDTH-1:0] mask
    );
        return WIDTH'(merge(MERGE_W'(old_val), MERGE_W'(new_val), MERGE_W'(mask)));
    endfunction

    assign wr_val = merge_entry(mem[windex], datain, wmask);

    // A write to the set being read on the same edge is forwarded so the read
    // returns the post-write value rather than the stale entry.
    assign rd_val = (we && (windex == rindex)) ? wr_val : mem[rindex];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_index] <= '0;
        end else if (we) begin
            mem[windex] <= wr_val;
        end
    end

    // ---- stage p1: registered read ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else if (read) begin
            rd_data_p1 <= rd_val;
        end
    end

    assign dataout = rd_data_p1;

endmodule

// File: rtl/meta_array.sv
// -----------------------------------------------------------------------------
// meta_array
//   N-way cache metadata array (tags, valid/dirty, LRU) with per-way write
//   enables, a shared per-bit write mask, a 1-cycle registered read with
//   write-through bypass, and a self-timed clear sweep.
//   Ports:
//     clk   clock
//     rst   asynchronous active-high reset: storage, dataout, FSM, counter -> 0
//     bus   meta_array_if.slave
//             read/rindex              registered read request
//             load[WAYS]/windex/wmask/datain  masked per-way write
//             clear                    start clear sweep (pulse)
//             dataout[WAYS*WIDTH]      read data, way w at [w*WIDTH +: WIDTH]
//             busy                     sweep in progress (NUM_SETS cycles)
//   While busy, read, load and clear are ignored; dataout holds.
// -----------------------------------------------------------------------------
module meta_array
    import meta_array_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 1,
    parameter int WAYS    = 2
) (
    input  logic          clk,
    input  logic          rst,
    meta_array_if.slave   bus
);

    localparam int                 NUM_SETS = 2 ** S_INDEX;
    localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);

    meta_state_e           state;
    meta_state_e           state_nxt;
    logic [S_INDEX-1:0]    cnt;
    logic [S_INDEX-1:0]    cnt_nxt;
    logic                  sweep;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [WAYS*WIDTH-1:0] dout_all;

    // busy comes straight from the state register, so no input reaches it
    // combinationally.
    assign sweep = (state == CLEAR);
    assign wr_ok = ~sweep;
    assign rd_ok = bus.read & ~sweep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                // One set per cycle; the edge that clears the last set also
                // returns to IDLE, giving exactly NUM_SETS busy cycles.
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_SET) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        meta_way #(
            .S_INDEX (S_INDEX),
            .WIDTH   (WIDTH)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .we        (bus.load[w] & wr_ok),
            .windex    (bus.windex),
            .wmask     (bus.wmask),
            .datain    (bus.datain),
            .read      (rd_ok),
            .rindex    (bus.rindex),
            .clr_we    (sweep),
            .clr_index (cnt),
            .dataout   (dout_all[w*WIDTH +: WIDTH])
        );
    end

    assign bus.dataout = dout_all;
    assign bus.busy    = sweep;

endmodule

// File: tb/tb_meta_array.sv
// -----------------------------------------------------------------------------
// tb_meta_array
//   Directed scoreboard bench for meta_array (S_INDEX=3, WIDTH=8, WAYS=2).
//   Stimulus pushes expected dataout/busy values tagged with the cycle they
//   are due; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_meta_array;

    localparam int S_INDEX = 3;
    localparam int WIDTH   = 8;
    localparam int WAYS    = 2;

    typedef struct {
        string       name;
        bit          is_busy;
        logic [15:0] val;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    meta_array_if #(.S_INDEX(S_INDEX), .WIDTH(WIDTH), .WAYS(WAYS)) bus ();

    meta_array #(
        .S_INDEX (S_INDEX),
        .WIDTH   (WIDTH),
        .WAYS    (WAYS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every expectation due this cycle; late ones are failures.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                if (sb[i].due < cyc) begin
                    check({sb[i].name, "_missed"}, 16'(sb[i].due), 16'(cyc));
                end else if (sb[i].is_busy) begin
                    check(sb[i].name, {15'b0, bus.busy}, sb[i].val);
                end else begin
                    check(sb[i].name, bus.dataout, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic exp_d(input string name, input logic [15:0] v);
        sb.push_back('{name: name, is_busy: 1'b0, val: v, due: cyc + 1});
    endtask

    task automatic exp_b(input string name, input bit v, input int due);
        sb.push_back('{name: name, is_busy: 1'b1, val: {15'b0, v}, due: due});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.read  = 1'b0;
        bus.load  = '0;
        bus.clear = 1'b0;
    endtask

    task automatic fill_ff();
        for (int i = 0; i < 8; i++) begin
            bus.load   = 2'b11;
            bus.windex = 3'(i);
            bus.datain = 8'hFF;
            bus.wmask  = 8'hFF;
            tick();
        end
        bus.load = '0;
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 8; i++) begin
            bus.read   = 1'b1;
            bus.rindex = 3'(i);
            exp_d(name, 16'h0000);
            tick();
        end
        bus.read = 1'b0;
    endtask

    task automatic busy_window(input string name, input int c);
        for (int k = 1; k <= 8; k++) exp_b(name, 1'b1, c + k);
        exp_b({name, "_fall"}, 1'b0, c + 9);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        bus.rindex = '0;
        bus.windex = '0;
        bus.wmask  = '0;
        bus.datain = '0;
        repeat (2) tick();
        check("reset_dataout", bus.dataout, 16'h0000);
        check("reset_busy", {15'b0, bus.busy}, 16'h0000);
        rst = 1'b0;
        tick();

        // Masked write, then read back
        bus.load = 2'b01; bus.windex = 3; bus.datain = 8'hAB; bus.wmask = 8'hFF;
        tick();
        bus.datain = 8'h00; bus.wmask = 8'h0F;
        tick();
        bus.load = '0; bus.read = 1'b1; bus.rindex = 3;
        exp_d("masked_rd", 16'h00A0);
        tick();

        // Same-edge write and read of set 5: bypass, then hold
        bus.read = 1'b1; bus.rindex = 5;
        bus.load = 2'b10; bus.windex = 5; bus.datain = 8'h5C; bus.wmask = 8'hFF;
        exp_d("bypass", 16'h5C00);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            exp_d("hold", 16'h5C00);
            tick();
        end
        bus.read = 1'b1; bus.rindex = 5;
        exp_d("set5_stored", 16'h5C00);
        tick();

        // Write at set 2 with read of set 6: no bypass
        bus.load = 2'b11; bus.windex = 2; bus.datain = 8'h77; bus.wmask = 8'hFF;
        bus.read = 1'b1; bus.rindex = 6;
        exp_d("no_bypass", 16'h0000);
        tick();
        bus.load = 2'b10; bus.datain = 8'h00; bus.wmask = 8'hF0; bus.read = 1'b0;
        tick();
        bus.load = '0; bus.read = 1'b1; bus.rindex = 2;
        exp_d("set2_way1_masked", 16'h0777);
        tick();
        idle();
        tick();

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dataout", bus.dataout, 16'h0000);
        check("async_rst_busy", {15'b0, bus.busy}, 16'h0000);
        tick();
        rst = 1'b0;
        bus.read = 1'b1; bus.rindex = 2;
        exp_d("post_rst_set2", 16'h0000);
        tick();
        bus.rindex = 5;
        exp_d("post_rst_set5", 16'h0000);
        tick();
        idle();

        // Full clear sweep, with same-edge read and ignored requests while busy
        fill_ff();
        bus.read = 1'b1; bus.rindex = 4; bus.clear = 1'b1;
        c = cyc;
        busy_window("sweep_busy", c);
        exp_d("clr_edge_rd", 16'hFFFF);
        tick();
        idle();
        tick();
        bus.load = 2'b01; bus.windex = 7; bus.datain = 8'h5A; bus.wmask = 8'hFF;
        bus.read = 1'b1; bus.rindex = 0;
        exp_d("rd_ignored_busy", 16'hFFFF);
        tick();
        idle();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        repeat (4) tick();
        bus.load = 2'b11; bus.windex = 0; bus.datain = 8'hC3;
        tick();
        idle();
        read_all_zero("swept_zero");

        // Reset during the sweep
        fill_ff();
        bus.read = 1'b1; bus.rindex = 6;
        exp_d("pre_abort_rd", 16'hFFFF);
        tick();
        idle();
        bus.clear = 1'b1;
        c = cyc;
        for (int k = 1; k <= 3; k++) exp_b("abort_busy", 1'b1, c + k);
        tick();
        bus.clear = 1'b0;
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        check("abort_busy_low", {15'b0, bus.busy}, 16'h0000);
        check("abort_dataout", bus.dataout, 16'h0000);
        tick();
        rst = 1'b0;
        read_all_zero("abort_zero");

        // Fresh sweep after reset runs the full length
        bus.clear = 1'b1;
        c = cyc;
        busy_window("resweep_busy", c);
        tick();
        bus.clear = 1'b0;
        repeat (10) tick();

        check("sb_drain", 16'(sb.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
